bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 clock  in  1  sole clock; all state on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces the reset state immediately, independent of clock.
REQ-003 f_req  in  1  fetch requester (port F) request; held until f_ack.
REQ-004 f_addr  in  20  port F byte address, stable while f_req.
REQ-005 f_ack  out  1  one-cycle pulse, port F transfer complete.
REQ-006 d_req  in  1  data requester (port D) request; held until d_ack.
REQ-007 d_addr  in  20  port D byte address, stable while d_req.
REQ-008 d_wide  in  1  port D 16-bit access (low byte at d_addr, high at d_addr+1).
REQ-009 d_we  in  1  port D write (1) / read (0).
REQ-010 d_wdata  in  16  port D write data; [7:0] low byte, [15:8] high byte.
REQ-011 d_ack  out  1  one-cycle pulse, port D transfer complete.
REQ-012 rdata  out  16  read result of the completed transfer; valid in the ack cycle, held until the next ack.
REQ-013 address  out  20  memory byte address.
REQ-014 data  in  8  memory read byte; valid in the same cycle as address.
REQ-015 out  out  8  memory write byte.
REQ-016 wren  out  1  memory write enable.

Function
REQ-017 States: IDLE, LO, HI, ACK; 2-bit encoding; transitions only on the rising edge of clock.
REQ-018 IDLE: no request -> IDLE; any request -> latch winner's addr/wide/we/wdata, go LO.
REQ-019 Port F is always byte-wide, read-only; its wide and we are treated as 0.
REQ-020 Arbitration: round-robin; one-bit pointer names the preferred port; a lone requester always wins.
REQ-021 When both request, the preferred port wins; the pointer then names the loser.
REQ-022 LO: address=latched addr; out=wdata[7:0]; wren=we; data sampled into rdata[7:0] at the end of the cycle; wide -> HI, else -> ACK.
REQ-023 HI: address=(addr+1) mod 2^20, so 0xFFFFF wraps to 0x00000; out=wdata[15:8]; wren=we; data sampled into rdata[15:8]; -> ACK.
REQ-024 Byte read: rdata[15:8]=0x00. On writes, rdata is unchanged.
REQ-025 ACK: the winner's ack = 1 for exactly this cycle; wren=0; no arbitration; -> IDLE.
REQ-026 Requests seen in ACK are ignored. The requester drops req, or presents a new request, from the cycle after ack.
REQ-027 Latency from IDLE with req: byte = 3 cycles (IDLE, LO, ACK); wide = 4 cycles.
REQ-028 In IDLE and ACK: address=0, out=0x00, wren=0.
REQ-029 wren is never high outside LO/HI, and only when the latched we=1.
REQ-030 Request inputs changing after latching in IDLE do not affect the transfer in flight.

Reset
REQ-031 Reset state: state=IDLE; f_ack=d_ack=0; rdata=0x0000; wren=0; address=0; out=0x00; pointer=port D preferred; latched request fields cleared.
REQ-032 Reset asserted in LO or HI drops wren immediately, aborts the transfer without an ack, and restarts in IDLE after release.

Verification
REQ-033 Port F only, f_addr=0x08000, data=0x3C -> address=0x08000 in LO; f_ack one cycle later with rdata=0x003C; 3 cycles total.
REQ-034 Port D wide write, d_addr=0x1234F, wdata=0xBEEF -> LO: address 0x1234F, out 0xEF, wren=1; HI: address 0x12350, out 0xBE, wren=1; then d_ack; rdata unchanged.
REQ-035 Port D wide read at 0xFFFFF, memory bytes 0x11 at 0xFFFFF and 0x22 at 0x00000 -> HI address=0x00000; rdata=0x2211 at d_ack.
REQ-036 F and D both held continuously from reset -> grants alternate D, F, D, F; no ack for one port while the other's transfer is in flight.
REQ-037 Reset asserted mid-HI of a wide write -> wren=0 in the same cycle; no d_ack; after release state=IDLE and the bus is idle.

Source files
------------

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Shares one byte-wide memory port between a fetch requester (port F,
//   byte reads only) and a data requester (port D, byte/16-bit, read/write).
//   Each transfer is IDLE -> LO [-> HI] -> ACK; a wide access uses the byte at
//   the latched address and the next one (wrapping at the top of the 20-bit
//   space). Contention is resolved round-robin with a one-bit preference.
//
// Ports
//   clock, reset            : clock, asynchronous active-high reset
//   f_req/f_addr/f_ack      : port F request, byte address, completion pulse
//   d_req/d_addr/d_wide/d_we/d_wdata/d_ack
//                           : port D request, address, 16-bit flag, write flag,
//                             write data, completion pulse
//   rdata                   : read result, valid from the ack until next ack
//   address/data/out/wren   : memory byte address, read byte, write byte,
//                             write enable
// -----------------------------------------------------------------------------
module bus_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [19:0] f_addr,
  output logic        f_ack,
  input  logic        d_req,
  input  logic [19:0] d_addr,
  input  logic        d_wide,
  input  logic        d_we,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] rdata,
  output logic [19:0] address,
  input  logic [7:0]  data,
  output logic [7:0]  out,
  output logic        wren
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_ACK  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic        r_pref_d;   // 1: port D preferred on contention, 0: port F
  logic        r_own_d;    // owner of the transfer in flight (1 = port D)
  logic [19:0] r_addr;
  logic        r_wide;
  logic        r_we;
  logic [15:0] r_wdata;
  logic [7:0]  r_lo_byte;  // low byte of a wide read, held until the HI byte arrives
  logic [15:0] r_rdata;

  logic        w_any_req;
  logic        w_grant_d;
  logic [19:0] w_addr_hi;

  // A lone requester always wins; on contention the preferred port wins.
  always_comb begin
    w_any_req = f_req | d_req;
    w_grant_d = d_req & (~f_req | r_pref_d);
  end

  // 20-bit add: 0xFFFFF + 1 wraps to 0x00000.
  assign w_addr_hi = r_addr + 20'd1;

  assign rdata = r_rdata;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and bus outputs. Outputs decode directly from the state
  // register so an asynchronous reset drops wren/address in the same cycle.
  always_comb begin
    w_state_next = r_state;
    address      = 20'h00000;
    out          = 8'h00;
    wren         = 1'b0;
    f_ack        = 1'b0;
    d_ack        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_next = ST_LO;
        end
      end
      ST_LO: begin
        address      = r_addr;
        out          = r_wdata[7:0];
        wren         = r_we;
        w_state_next = r_wide ? ST_HI : ST_ACK;
      end
      ST_HI: begin
        address      = w_addr_hi;
        out          = r_wdata[15:8];
        wren         = r_we;
        w_state_next = ST_ACK;
      end
      ST_ACK: begin
        // Requests are not looked at here; arbitration resumes in IDLE.
        f_ack        = ~r_own_d;
        d_ack        = r_own_d;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Request latch, arbitration pointer and read-data capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pref_d  <= 1'b1;
      r_own_d   <= 1'b0;
      r_addr    <= 20'h00000;
      r_wide    <= 1'b0;
      r_we      <= 1'b0;
      r_wdata   <= 16'h0000;
      r_lo_byte <= 8'h00;
      r_rdata   <= 16'h0000;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            // Port F is forced to a byte read with no write data.
            r_own_d <= w_grant_d;
            r_addr  <= w_grant_d ? d_addr : f_addr;
            r_wide  <= w_grant_d & d_wide;
            r_we    <= w_grant_d & d_we;
            r_wdata <= w_grant_d ? d_wdata : 16'h0000;
            // After contention the pointer names the port that lost.
            if (f_req & d_req) begin
              r_pref_d <= ~w_grant_d;
            end
          end
        end
        ST_LO: begin
          if (!r_we) begin
            if (r_wide) begin
              // Stage the low byte so rdata keeps the previous result
              // until this transfer's ack.
              r_lo_byte <= data;
            end else begin
              r_rdata <= {8'h00, data};
            end
          end
        end
        ST_HI: begin
          if (!r_we) begin
            r_rdata <= {data, r_lo_byte};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        f_req;
  logic [19:0] f_addr;
  logic        f_ack;
  logic        d_req;
  logic [19:0] d_addr;
  logic        d_wide;
  logic        d_we;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] rdata;
  logic [19:0] address;
  logic [7:0]  data;
  logic [7:0]  out;
  logic        wren;

  // Memory contents: a fixed hash of the address, with two override slots
  // for directed scenarios.
  logic        ov_en;
  logic [19:0] ov_a0, ov_a1;
  logic [7:0]  ov_d0, ov_d1;

  int total = 0;
  int bad   = 0;

  // Reference model state: who is preferred, and what rdata should hold.
  bit          ptr_d;
  logic [15:0] exp_rdata;

  bus_arbiter dut (
    .clock   (clock),
    .reset   (reset),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_ack   (f_ack),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_wide  (d_wide),
    .d_we    (d_we),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .rdata   (rdata),
    .address (address),
    .data    (data),
    .out     (out),
    .wren    (wren)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] mem_byte(input logic [19:0] a, input logic en,
                                          input logic [19:0] a0, input logic [7:0] d0,
                                          input logic [19:0] a1, input logic [7:0] d1);
    logic [19:0] t;
    if (en && a == a0) return d0;
    if (en && a == a1) return d1;
    t = (a * 20'd37) ^ (a >> 7);
    return t[7:0] ^ 8'h5A;
  endfunction

  assign data = mem_byte(address, ov_en, ov_a0, ov_d0, ov_a1, ov_d1);

  function automatic logic [19:0] pick_addr();
    if ($urandom_range(0, 7) == 0) return 20'hFFFFF;
    return 20'($urandom);
  endfunction

  task automatic rand_f();
    f_req  = 1'b1;
    f_addr = pick_addr();
  endtask

  task automatic rand_d();
    d_req   = 1'b1;
    d_addr  = pick_addr();
    d_wide  = 1'($urandom);
    d_we    = 1'($urandom);
    d_wdata = 16'($urandom);
  endtask

  // One arbitration round. Called at a negedge with requests already on the
  // inputs. from_ack: the previous negedge showed an ack, so one IDLE cycle
  // comes first. scramble: drop and garble all request inputs right after
  // the first bus cycle (only used with a single requester).
  task automatic run_round(input bit from_ack, input bit scramble, output bit won_d);
    logic [19:0] a, ai, a1;
    logic        wide, we;
    logic [15:0] wd, want;
    logic [7:0]  ob;
    int          n;
    won_d = d_req && (!f_req || ptr_d);
    if (f_req && d_req) ptr_d = !won_d;
    a    = won_d ? d_addr : f_addr;
    wide = won_d && d_wide;
    we   = won_d && d_we;
    wd   = won_d ? d_wdata : 16'h0000;
    n    = wide ? 2 : 1;
    a1   = a + 20'd1;
    if (!we) want = wide ? {mem_byte(a1, ov_en, ov_a0, ov_d0, ov_a1, ov_d1), mem_byte(a, ov_en, ov_a0, ov_d0, ov_a1, ov_d1)}
                         : {8'h00, mem_byte(a, ov_en, ov_a0, ov_d0, ov_a1, ov_d1)};
    else     want = exp_rdata;
    if (from_ack) begin
      @(negedge clock);
      total++;
      if ({f_ack, d_ack, wren, address, out} !== 31'd0) begin
        bad++;
        $display("FAIL idle_gap: got ack f=%b d=%b wren=%b addr=%h out=%h, want all zero", f_ack, d_ack, wren, address, out);
      end
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ai = a + 20'(i);
      ob = (i == 0) ? wd[7:0] : wd[15:8];
      total++; if (address !== ai) begin bad++; $display("FAIL bus_addr[%0d]: got %h want %h", i, address, ai); end
      total++; if (out !== ob) begin bad++; $display("FAIL bus_out[%0d]: got %h want %h", i, out, ob); end
      total++; if (wren !== we) begin bad++; $display("FAIL bus_wren[%0d]: got %b want %b", i, wren, we); end
      total++; if ({f_ack, d_ack} !== 2'b00) begin bad++; $display("FAIL early_ack[%0d]: got f=%b d=%b want none", i, f_ack, d_ack); end
      if (scramble && i == 0) begin
        f_req = 1'b0; d_req = 1'b0;
        f_addr = 20'($urandom); d_addr = 20'($urandom);
        d_wide = 1'($urandom); d_we = 1'($urandom); d_wdata = 16'($urandom);
      end
    end
    exp_rdata = want;
    @(negedge clock);
    total++;
    if ({f_ack, d_ack} !== {!won_d, won_d}) begin
      bad++; $display("FAIL ack_port: got f=%b d=%b want f=%b d=%b", f_ack, d_ack, !won_d, won_d);
    end
    total++;
    if ({wren, address, out} !== 29'd0) begin
      bad++; $display("FAIL ack_bus: got wren=%b addr=%h out=%h want zero", wren, address, out);
    end
    total++;
    if (rdata !== want) begin
      bad++; $display("FAIL rdata: got %h want %h", rdata, want);
    end
    $display("txn port=%s addr=%h wide=%0d we=%0d wdata=%h rdata=%h", won_d ? "D" : "F", a, wide, we, wd, rdata);
  endtask

  task automatic drop_all();
    f_req = 1'b0;
    d_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_addr = '0;
    d_wide = 1'b0; d_we = 1'b0; d_wdata = '0;
    ov_en = 1'b0; ov_a0 = '0; ov_a1 = '0; ov_d0 = '0; ov_d1 = '0;
    repeat (2) @(negedge clock);
    total++; if ({f_ack, d_ack} !== 2'b00) begin bad++; $display("FAIL reset_ack: got f=%b d=%b want 0", f_ack, d_ack); end
    total++; if (rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    total++; if (wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", wren); end
    total++; if (address !== 20'h00000) begin bad++; $display("FAIL reset_addr: got %h want 00000", address); end
    total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out: got %h want 00", out); end
    reset = 1'b0;
    ptr_d = 1'b1;
    exp_rdata = 16'h0000;
    @(negedge clock);
    total++;
    if ({f_ack, d_ack, wren, address, out} !== 31'd0) begin
      bad++; $display("FAIL post_reset_idle: got ack f=%b d=%b wren=%b addr=%h out=%h want zero", f_ack, d_ack, wren, address, out);
    end
  endtask

  task automatic test_alternation();
    bit w;
    rand_f();
    rand_d();
    for (int k = 0; k < 4; k++) begin
      run_round(k > 0, 1'b0, w);
      total++;
      if (w !== ((k % 2 == 0) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL alt_order[%0d]: got winner %s want %s", k, w ? "D" : "F", (k % 2 == 0) ? "D" : "F");
      end
      if (w) rand_d(); else rand_f();
    end
    drop_all();
  endtask

  task automatic test_fetch_byte();
    bit w;
    ov_en = 1'b1; ov_a0 = 20'h08000; ov_d0 = 8'h3C; ov_a1 = 20'h08001; ov_d1 = 8'h77;
    f_req = 1'b1; f_addr = 20'h08000;
    run_round(1'b0, 1'b0, w);
    total++; if (rdata !== 16'h003C) begin bad++; $display("FAIL fetch_rdata: got %h want 003C", rdata); end
    drop_all();
    ov_en = 1'b0;
  endtask

  task automatic test_wide_write();
    bit w;
    logic [15:0] prev;
    prev = exp_rdata;
    d_req = 1'b1; d_addr = 20'h1234F; d_wide = 1'b1; d_we = 1'b1; d_wdata = 16'hBEEF;
    run_round(1'b0, 1'b0, w);
    total++; if (rdata !== prev) begin bad++; $display("FAIL write_keeps_rdata: got %h want %h", rdata, prev); end
    drop_all();
  endtask

  task automatic test_wide_read_wrap();
    bit w;
    ov_en = 1'b1; ov_a0 = 20'hFFFFF; ov_d0 = 8'h11; ov_a1 = 20'h00000; ov_d1 = 8'h22;
    d_req = 1'b1; d_addr = 20'hFFFFF; d_wide = 1'b1; d_we = 1'b0; d_wdata = 16'h5555;
    run_round(1'b0, 1'b0, w);
    total++; if (rdata !== 16'h2211) begin bad++; $display("FAIL wrap_rdata: got %h want 2211", rdata); end
    drop_all();
    ov_en = 1'b0;
  endtask

  task automatic test_inflight_change();
    bit w;
    rand_f();
    run_round(1'b0, 1'b1, w);
    drop_all();
    rand_d();
    d_wide = 1'b1;
    run_round(1'b0, 1'b1, w);
    drop_all();
  endtask

  task automatic test_random();
    bit w;
    bit from_ack;
    int r;
    r = $urandom_range(1, 3);
    if (r[0]) rand_f();
    if (r[1]) rand_d();
    from_ack = 1'b0;
    for (int k = 0; k < 40; k++) begin
      run_round(from_ack, 1'b0, w);
      if ($urandom_range(0, 3) != 0) begin
        if (w) rand_d(); else rand_f();
      end else begin
        if (w) d_req = 1'b0; else f_req = 1'b0;
      end
      from_ack = 1'b1;
      if (!f_req && !d_req) begin
        @(negedge clock);
        total++;
        if ({f_ack, d_ack, wren, address, out} !== 31'd0) begin
          bad++; $display("FAIL rand_idle: got ack f=%b d=%b wren=%b addr=%h out=%h want zero", f_ack, d_ack, wren, address, out);
        end
        if ($urandom_range(0, 1) != 0) rand_d(); else rand_f();
        from_ack = 1'b0;
      end
    end
    drop_all();
  endtask

  task automatic test_reset_mid_hi();
    bit w;
    logic [19:0] a, a1;
    rand_d();
    d_wide = 1'b1; d_we = 1'b1;
    a = d_addr; a1 = a + 20'd1;
    @(negedge clock);
    total++; if ({wren, address} !== {1'b1, a}) begin bad++; $display("FAIL mid_lo: got wren=%b addr=%h want 1 %h", wren, address, a); end
    @(negedge clock);
    total++; if ({wren, address} !== {1'b1, a1}) begin bad++; $display("FAIL mid_hi: got wren=%b addr=%h want 1 %h", wren, address, a1); end
    reset = 1'b1;
    #1;
    total++; if (wren !== 1'b0) begin bad++; $display("FAIL abort_wren: got %b want 0", wren); end
    total++; if ({address, out, d_ack} !== 29'd0) begin bad++; $display("FAIL abort_bus: got addr=%h out=%h d_ack=%b want zero", address, out, d_ack); end
    d_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    ptr_d = 1'b1;
    exp_rdata = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      total++;
      if ({f_ack, d_ack, wren, address, out} !== 31'd0 || rdata !== 16'h0000) begin
        bad++; $display("FAIL after_abort[%0d]: got ack f=%b d=%b wren=%b addr=%h out=%h rdata=%h want zero", i, f_ack, d_ack, wren, address, out, rdata);
      end
    end
    rand_f();
    run_round(1'b0, 1'b0, w);
    drop_all();
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_fetch_byte();
    test_wide_write();
    test_wide_read_wrap();
    test_inflight_change();
    test_random();
    test_reset_mid_hi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
